// File: rtl/fpu_arbiter_if.sv
// rtl/fpu_arbiter_if.sv - FPU wrapper handshake bundle shared by the arbiter and the FPU
interface fpu_arbiter_if;
    logic [1:0]  op_sel;
    logic [31:0] input_a;
    logic [31:0] input_b;
    logic        input_a_stb;
    logic        input_b_stb;
    logic        input_a_ack;
    logic        input_b_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;

    modport master (
        output op_sel, input_a, input_b, input_a_stb, input_b_stb, output_z_ack,
        input  input_a_ack, input_b_ack, output_z, output_z_stb
    );

    modport slave (
        input  op_sel, input_a, input_b, input_a_stb, input_b_stb, output_z_ack,
        output input_a_ack, input_b_ack, output_z, output_z_stb
    );
endinterface

// File: rtl/fpu_arbiter.sv
// rtl/fpu_arbiter.sv - round-robin sharing of one FPU wrapper between two requesters
module fpu_arbiter #(
    parameter int TIMEOUT   = 1023,
    parameter int SETTLE    = 2,
    parameter int FLUSH_CYC = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [1:0]   req0_op,
    input  logic [31:0]  req0_a,
    input  logic [31:0]  req0_b,
    output logic         req0_ready,
    output logic         rsp0_valid,
    output logic [31:0]  rsp0_z,
    output logic         rsp0_err,
    input  logic         rsp0_ack,
    input  logic         req1_valid,
    input  logic [1:0]   req1_op,
    input  logic [31:0]  req1_a,
    input  logic [31:0]  req1_b,
    output logic         req1_ready,
    output logic         rsp1_valid,
    output logic [31:0]  rsp1_z,
    output logic         rsp1_err,
    input  logic         rsp1_ack,
    fpu_arbiter_if.master fpu,
    output logic         busy,
    output logic         grant_id
);
    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_SEND, S_WAIT_Z, S_ACK_Z, S_FLUSH, S_RESP
    } state_t;

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX      = WD_W'(TIMEOUT);
    localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [7:0]      FLUSH_LAST  = 8'(FLUSH_CYC - 1);

    state_t            state;
    logic              ptr;
    logic [7:0]        cnt;
    logic [WD_W-1:0]   wd;
    logic [1:0]        op_sel_r;
    logic [31:0]       a_r;
    logic [31:0]       b_r;
    logic [31:0]       z_r;
    logic              err_r;
    logic              a_stb_r;
    logic              b_stb_r;
    logic              z_ack_r;
    logic              rsp0_v_r;
    logic              rsp1_v_r;

    logic              win_id;
    logic              win_valid;
    logic [1:0]        win_op;
    logic [31:0]       win_a;
    logic [31:0]       win_b;
    logic              accept;
    logic              wd_hit;
    logic              a_done;
    logic              b_done;
    logic              rsp_ack_g;

    // Preferred port wins when valid; otherwise the other port takes the slot.
    always_comb begin
        win_id    = ptr ? req1_valid : ~req0_valid;
        win_valid = req0_valid | req1_valid;
        win_op    = win_id ? req1_op : req0_op;
        win_a     = win_id ? req1_a : req0_a;
        win_b     = win_id ? req1_b : req0_b;
    end

    assign req0_ready = (state == S_IDLE) && win_valid && !win_id;
    assign req1_ready = (state == S_IDLE) && win_valid && win_id;
    assign accept     = req0_ready | req1_ready;
    assign wd_hit     = (wd == WD_MAX);
    assign a_done     = !a_stb_r || fpu.input_a_ack;
    assign b_done     = !b_stb_r || fpu.input_b_ack;
    assign rsp_ack_g  = grant_id ? rsp1_ack : rsp0_ack;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            ptr      <= 1'b0;
            grant_id <= 1'b0;
            cnt      <= '0;
            wd       <= '0;
            op_sel_r <= 2'b00;
            a_r      <= '0;
            b_r      <= '0;
            z_r      <= '0;
            err_r    <= 1'b0;
            a_stb_r  <= 1'b0;
            b_stb_r  <= 1'b0;
            z_ack_r  <= 1'b0;
            rsp0_v_r <= 1'b0;
            rsp1_v_r <= 1'b0;
        end else begin
            if ((state == S_SEND || state == S_WAIT_Z || state == S_ACK_Z) && !wd_hit)
                wd <= wd + WD_W'(1);
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        grant_id <= win_id;
                        a_r      <= win_a;
                        b_r      <= win_b;
                        cnt      <= '0;
                        if (win_op == 2'b00) begin
                            err_r    <= 1'b1;
                            z_r      <= '0;
                            rsp0_v_r <= !win_id;
                            rsp1_v_r <= win_id;
                            state    <= S_RESP;
                        end else begin
                            op_sel_r <= win_op;
                            state    <= S_SETTLE;
                        end
                    end
                end
                S_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        a_stb_r <= 1'b1;
                        b_stb_r <= 1'b1;
                        wd      <= '0;
                        state   <= S_SEND;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_SEND: begin
                    if (wd_hit) begin
                        err_r    <= 1'b1;
                        z_r      <= '0;
                        a_stb_r  <= 1'b0;
                        b_stb_r  <= 1'b0;
                        op_sel_r <= 2'b00;
                        cnt      <= '0;
                        state    <= S_FLUSH;
                    end else begin
                        if (a_stb_r && fpu.input_a_ack) a_stb_r <= 1'b0;
                        if (b_stb_r && fpu.input_b_ack) b_stb_r <= 1'b0;
                        if (a_done && b_done) state <= S_WAIT_Z;
                    end
                end
                S_WAIT_Z: begin
                    // A result arriving on the timeout cycle still counts as success.
                    if (fpu.output_z_stb) begin
                        z_r     <= fpu.output_z;
                        err_r   <= 1'b0;
                        z_ack_r <= 1'b1;
                        state   <= S_ACK_Z;
                    end else if (wd_hit) begin
                        err_r    <= 1'b1;
                        z_r      <= '0;
                        op_sel_r <= 2'b00;
                        cnt      <= '0;
                        state    <= S_FLUSH;
                    end
                end
                S_ACK_Z: begin
                    if (!fpu.output_z_stb || wd_hit) begin
                        if (fpu.output_z_stb) begin
                            err_r <= 1'b1;
                            z_r   <= '0;
                        end
                        z_ack_r  <= 1'b0;
                        op_sel_r <= 2'b00;
                        cnt      <= '0;
                        state    <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (cnt == FLUSH_LAST) begin
                        rsp0_v_r <= !grant_id;
                        rsp1_v_r <= grant_id;
                        state    <= S_RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ack_g) begin
                        rsp0_v_r <= 1'b0;
                        rsp1_v_r <= 1'b0;
                        ptr      <= ~grant_id;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy             = (state != S_IDLE);
    assign fpu.op_sel       = op_sel_r;
    assign fpu.input_a      = a_r;
    assign fpu.input_b      = b_r;
    assign fpu.input_a_stb  = a_stb_r;
    assign fpu.input_b_stb  = b_stb_r;
    assign fpu.output_z_ack = z_ack_r;

    assign rsp0_valid = rsp0_v_r;
    assign rsp1_valid = rsp1_v_r;
    assign rsp0_z     = rsp0_v_r ? z_r : '0;
    assign rsp1_z     = rsp1_v_r ? z_r : '0;
    assign rsp0_err   = rsp0_v_r & err_r;
    assign rsp1_err   = rsp1_v_r & err_r;
endmodule

// File: tb/tb_fpu_arbiter.sv
// tb/tb_fpu_arbiter.sv - directed bench for fpu_arbiter with a table-driven FPU responder
module tb_fpu_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [1:0]  req0_op = 2'b00, req1_op = 2'b00;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_z, rsp1_z;
    logic        rsp0_err, rsp1_err;
    logic        rsp0_ack = 1'b0, rsp1_ack = 1'b0;
    logic        busy, grant_id;

    fpu_arbiter_if fpu_bus ();

    fpu_arbiter #(.TIMEOUT(16), .SETTLE(2), .FLUSH_CYC(2)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_z(rsp0_z),
        .rsp0_err(rsp0_err), .rsp0_ack(rsp0_ack),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_z(rsp1_z),
        .rsp1_err(rsp1_err), .rsp1_ack(rsp1_ack),
        .fpu(fpu_bus), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // FPU responder knobs and state
    int a_delay = 0, b_delay = 0, z_delay = 2;
    bit z_never = 1'b0;
    int a_cnt, b_cnt, z_cnt, stb_count = 0;
    bit got_a, got_b, done;

    function automatic logic [31:0] fpu_ref(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case ({op, a, b})
            {2'b01, 32'h3F800000, 32'h40000000}: return 32'h40400000;
            {2'b01, 32'h40000000, 32'h3F800000}: return 32'h40400000;
            {2'b10, 32'h40000000, 32'h40400000}: return 32'h40C00000;
            {2'b11, 32'h40C00000, 32'h40000000}: return 32'h40400000;
            default:                             return 32'hBAD0BAD0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (fpu_bus.input_a_stb || fpu_bus.input_b_stb) stb_count++;
        if (!rst || fpu_bus.op_sel == 2'b00) begin
            fpu_bus.input_a_ack  = 1'b0;
            fpu_bus.input_b_ack  = 1'b0;
            fpu_bus.output_z_stb = 1'b0;
            fpu_bus.output_z     = '0;
            a_cnt = 0; b_cnt = 0; z_cnt = 0;
            got_a = 1'b0; got_b = 1'b0; done = 1'b0;
        end else begin
            if (fpu_bus.input_a_stb) begin
                fpu_bus.input_a_ack = (a_cnt >= a_delay);
                if (fpu_bus.input_a_ack) got_a = 1'b1;
                a_cnt++;
            end else begin
                fpu_bus.input_a_ack = 1'b0;
                a_cnt = 0;
            end
            if (fpu_bus.input_b_stb) begin
                fpu_bus.input_b_ack = (b_cnt >= b_delay);
                if (fpu_bus.input_b_ack) got_b = 1'b1;
                b_cnt++;
            end else begin
                fpu_bus.input_b_ack = 1'b0;
                b_cnt = 0;
            end
            if (fpu_bus.output_z_stb && fpu_bus.output_z_ack) begin
                fpu_bus.output_z_stb = 1'b0;
                done = 1'b1;
            end else if (got_a && got_b && !done && !z_never && !fpu_bus.output_z_stb) begin
                if (z_cnt >= z_delay) begin
                    fpu_bus.output_z_stb = 1'b1;
                    fpu_bus.output_z     = fpu_ref(fpu_bus.op_sel, fpu_bus.input_a, fpu_bus.input_b);
                end else begin
                    z_cnt++;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit port, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        if (port) begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
        else      begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
        #1;
        n = 0;
        while (!(port ? req1_ready : req0_ready) && n < 200) begin tick(); n++; end
        check("accept_bound", 32'(n < 200), 32'd1);
        tick();
        if (port) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_rsp(input bit port, output int cyc);
        cyc = 0;
        while (!(port ? rsp1_valid : rsp0_valid) && cyc < 200) begin tick(); cyc++; end
        check("rsp_bound", 32'(cyc < 200), 32'd1);
    endtask

    task automatic ack_rsp(input bit port);
        if (port) rsp1_ack = 1'b1; else rsp0_ack = 1'b1;
        tick();
        rsp0_ack = 1'b0;
        rsp1_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int cyc;
        int snap;
        logic [1:0] h1, h2, h3;
        h1 = 2'b00; h2 = 2'b00; h3 = 2'b00;

        // Reset state
        rst = 1'b0;
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_op_sel", fpu_bus.op_sel, 0);
        check("rst_stb", {fpu_bus.input_a_stb, fpu_bus.input_b_stb, fpu_bus.output_z_ack}, 0);
        check("rst_rsp", {rsp0_valid, rsp1_valid, req0_ready, req1_ready}, 0);
        check("rst_grant", grant_id, 0);
        rst = 1'b1;
        tick();

        // Add on port 0 with exact SETTLE/FLUSH timing
        req0_valid = 1'b1; req0_op = 2'b01; req0_a = 32'h3F800000; req0_b = 32'h40000000;
        #1;
        check("add_ready", {req0_ready, req1_ready}, 2'b10);
        tick();
        req0_valid = 1'b0;
        check("add_settle0_busy", busy, 1);
        check("add_settle0_op", fpu_bus.op_sel, 2'b01);
        check("add_settle0_stb", fpu_bus.input_a_stb, 0);
        tick();
        check("add_settle1_stb", {fpu_bus.input_a_stb, fpu_bus.input_b_stb}, 0);
        tick();
        check("add_send_stb", {fpu_bus.input_a_stb, fpu_bus.input_b_stb}, 2'b11);
        check("add_operand_a", fpu_bus.input_a, 32'h3F800000);
        check("add_operand_b", fpu_bus.input_b, 32'h40000000);
        cyc = 0;
        while (!rsp0_valid && cyc < 100) begin
            h3 = h2; h2 = h1; h1 = fpu_bus.op_sel;
            tick(); cyc++;
        end
        check("add_rsp_seen", rsp0_valid, 1);
        check("add_flush_ops", {h3, h2, h1}, 6'b01_00_00);
        check("add_z", rsp0_z, 32'h40400000);
        check("add_err", rsp0_err, 0);
        check("add_rsp1_quiet", rsp1_valid, 0);
        ack_rsp(1'b0);
        check("add_idle", {busy, rsp0_valid}, 0);

        // Back-to-back on port 1: mul then div
        send(1'b1, 2'b10, 32'h40000000, 32'h40400000);
        wait_rsp(1'b1, cyc);
        check("mul_z", rsp1_z, 32'h40C00000);
        check("mul_err", rsp1_err, 0);
        check("mul_grant", grant_id, 1);
        check("mul_resp_op_sel", fpu_bus.op_sel, 0);
        ack_rsp(1'b1);
        send(1'b1, 2'b11, 32'h40C00000, 32'h40000000);
        wait_rsp(1'b1, cyc);
        check("div_z", rsp1_z, 32'h40400000);
        check("div_rsp0_quiet", rsp0_valid, 0);
        ack_rsp(1'b1);

        // Both ports persistently valid from reset: grants alternate 0,1,0,1
        rst = 1'b0; tick(); rst = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b10; req0_a = 32'h40000000; req0_b = 32'h40400000;
        req1_valid = 1'b1; req1_op = 2'b01; req1_a = 32'h3F800000; req1_b = 32'h40000000;
        for (int k = 0; k < 4; k++) begin
            cyc = 0;
            while (!(rsp0_valid || rsp1_valid) && cyc < 200) begin tick(); cyc++; end
            check("rr_grant", grant_id, 32'(k % 2));
            if (k % 2 == 0) begin
                check("rr_rsp0_z", rsp0_z, 32'h40C00000);
                ack_rsp(1'b0);
            end else begin
                check("rr_rsp1_z", rsp1_z, 32'h40400000);
                ack_rsp(1'b1);
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        // Invalid op on port 1, plus ack on the wrong port being ignored
        snap = stb_count;
        send(1'b1, 2'b00, 32'h3F800000, 32'h3F800000);
        check("inv_rsp_valid", rsp1_valid, 1);
        check("inv_err", rsp1_err, 1);
        check("inv_z", rsp1_z, 0);
        ack_rsp(1'b0);
        check("inv_wrong_ack", {busy, rsp1_valid}, 2'b11);
        ack_rsp(1'b1);
        check("inv_no_strobes", 32'(stb_count - snap), 0);

        // Watchdog abort with a acked 3 cycles before b
        z_never = 1'b1; b_delay = 3;
        send(1'b0, 2'b01, 32'h3F800000, 32'h40000000);
        cyc = 0;
        while (!fpu_bus.input_a_stb && cyc < 20) begin tick(); cyc++; end
        check("to_stb_rise", {fpu_bus.input_a_stb, fpu_bus.input_b_stb}, 2'b11);
        tick();
        check("to_a_drop_first", {fpu_bus.input_a_stb, fpu_bus.input_b_stb}, 2'b01);
        tick(); tick();
        check("to_b_still_high", fpu_bus.input_b_stb, 1);
        tick();
        check("to_b_dropped", fpu_bus.input_b_stb, 0);
        cyc = 4;
        while (!rsp0_valid && cyc < 100) begin h1 = fpu_bus.op_sel; tick(); cyc++; end
        check("to_window", 32'(cyc >= 16 && cyc <= 30), 32'd1);
        check("to_flush_op_sel", h1, 0);
        check("to_err", rsp0_err, 1);
        check("to_z", rsp0_z, 0);
        ack_rsp(1'b0);
        z_never = 1'b0; b_delay = 0;
        send(1'b1, 2'b01, 32'h40000000, 32'h3F800000);
        wait_rsp(1'b1, cyc);
        check("post_to_z", rsp1_z, 32'h40400000);
        check("post_to_err", rsp1_err, 0);
        ack_rsp(1'b1);

        // Reset mid-WAIT_Z abandons the operation
        z_never = 1'b1;
        send(1'b1, 2'b01, 32'h3F800000, 32'h40000000);
        for (int k = 0; k < 6; k++) tick();
        check("mid_waiting", {busy, fpu_bus.input_a_stb, fpu_bus.input_b_stb}, 3'b100);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_op_sel", fpu_bus.op_sel, 0);
        check("mid_rst_outs", {fpu_bus.input_a_stb, fpu_bus.input_b_stb, fpu_bus.output_z_ack, grant_id}, 0);
        check("mid_rst_a", fpu_bus.input_a, 0);
        for (int k = 0; k < 5; k++) tick();
        check("mid_no_rsp", {rsp0_valid, rsp1_valid, busy}, 0);
        z_never = 1'b0;
        send(1'b0, 2'b01, 32'h3F800000, 32'h40000000);
        wait_rsp(1'b0, cyc);
        check("mid_after_z", rsp0_z, 32'h40400000);
        check("mid_after_err", rsp0_err, 0);
        ack_rsp(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
